// File: rtl/cpu16_pkg.sv
// Shared constants for the cpu16 ALU datapath: widths, instruction field positions and ALU codes.
package cpu16_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned REG_AW    = 2;

  localparam int unsigned CLASS_MSB = 15;
  localparam int unsigned CLASS_LSB = 8;
  localparam int unsigned FUNC_MSB  = 7;
  localparam int unsigned FUNC_LSB  = 4;
  localparam int unsigned RA_MSB    = 3;
  localparam int unsigned RA_LSB    = 2;
  localparam int unsigned RB_MSB    = 1;
  localparam int unsigned RB_LSB    = 0;

  localparam logic [7:0] CLASS_ALU = 8'h00;

  localparam logic [3:0] FUNC_ADD = 4'h0;
  localparam logic [3:0] FUNC_SUB = 4'h2;
  localparam logic [3:0] FUNC_NOT = 4'h8;
  localparam logic [3:0] FUNC_AND = 4'hA;
  localparam logic [3:0] FUNC_OR  = 4'hC;
  localparam logic [3:0] FUNC_XOR = 4'hE;

  typedef struct packed {
    logic s_sub;
    logic s_fas;
    logic s_and;
    logic s_or;
    logic s_xor;
    logic s_not;
  } alu_sel_t;

endpackage

// File: rtl/cpu16_alu.sv
// Combinational ALU: add/sub, and, or, xor, not driven by one-hot selects.
module cpu16_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_fas,
  input  logic             i_and,
  input  logic             i_or,
  input  logic             i_xor,
  input  logic             i_not,
  output logic [WIDTH-1:0] o_r,
  output logic             o_cout
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum_ext;

  // Subtract as A + ~B + 1, so carry-out of 1 means no borrow.
  assign w_b_eff   = i_sub ? ~i_b : i_b;
  assign w_sum_ext = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};

  always_comb begin
    o_r    = '0;
    o_cout = 1'b0;
    if (i_fas) begin
      o_r    = w_sum_ext[WIDTH-1:0];
      o_cout = w_sum_ext[WIDTH];
    end else if (i_and) begin
      o_r = i_a & i_b;
    end else if (i_or) begin
      o_r = i_a | i_b;
    end else if (i_xor) begin
      o_r = i_a ^ i_b;
    end else if (i_not) begin
      o_r = ~i_a;
    end
  end

endmodule

// File: rtl/cpu16_alu_core.sv
// Single-cycle 16-bit datapath: decoder, register file with host port, ALU and carry flag.
// Optional zero flag output enabled by defining CPU16_ZFLAG_EN.
module cpu16_alu_core
  import cpu16_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned NREGS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [15:0]       i_ir,
  input  logic              i_exec,
  input  logic              i_host_we,
  input  logic [REG_AW-1:0] i_host_addr,
  input  logic [WIDTH-1:0]  i_host_wdata,
  output logic [WIDTH-1:0]  o_r,
  output logic              o_cout,
  output logic              o_is_alu,
  output logic              o_s_sub,
  output logic              o_s_fas,
  output logic              o_s_and,
  output logic              o_s_or,
  output logic              o_s_xor,
  output logic              o_s_not,
  output logic              o_cflag,
`ifdef CPU16_ZFLAG_EN
  output logic              o_zflag,
`endif
  output logic [WIDTH-1:0]  o_reg_a,
  output logic [WIDTH-1:0]  o_reg_b
);

  logic [7:0]        w_class;
  logic [3:0]        w_func;
  logic [REG_AW-1:0] w_ra;
  logic [REG_AW-1:0] w_rb;
  alu_sel_t          w_sel;
  logic              w_is_alu;
  logic [WIDTH-1:0]  w_r;
  logic              w_cout;
  logic              w_commit;

  logic [WIDTH-1:0]  r_regs [NREGS];
  logic              r_cflag;

  assign w_class = i_ir[CLASS_MSB:CLASS_LSB];
  assign w_func  = i_ir[FUNC_MSB:FUNC_LSB];
  assign w_ra    = i_ir[RA_MSB:RA_LSB];
  assign w_rb    = i_ir[RB_MSB:RB_LSB];

  always_comb begin
    w_sel    = '0;
    w_is_alu = 1'b0;
    if (w_class == CLASS_ALU) begin
      w_is_alu = 1'b1;
      case (w_func)
        FUNC_ADD: w_sel.s_fas = 1'b1;
        FUNC_SUB: begin
          w_sel.s_fas = 1'b1;
          w_sel.s_sub = 1'b1;
        end
        FUNC_NOT: w_sel.s_not = 1'b1;
        FUNC_AND: w_sel.s_and = 1'b1;
        FUNC_OR:  w_sel.s_or  = 1'b1;
        FUNC_XOR: w_sel.s_xor = 1'b1;
        default:  w_is_alu    = 1'b0;
      endcase
    end
  end

  assign o_reg_a = r_regs[w_ra];
  assign o_reg_b = r_regs[w_rb];

  cpu16_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_a    (o_reg_a),
    .i_b    (o_reg_b),
    .i_sub  (w_sel.s_sub),
    .i_fas  (w_sel.s_fas),
    .i_and  (w_sel.s_and),
    .i_or   (w_sel.s_or),
    .i_xor  (w_sel.s_xor),
    .i_not  (w_sel.s_not),
    .o_r    (w_r),
    .o_cout (w_cout)
  );

  assign w_commit = i_exec & w_is_alu;

  // Host write is applied last so it overrides a same-register writeback.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_cflag <= 1'b0;
    end else begin
      if (w_commit) begin
        r_regs[w_ra] <= w_r;
        r_cflag      <= w_cout;
      end
      if (i_host_we) begin
        r_regs[i_host_addr] <= i_host_wdata;
      end
    end
  end

`ifdef CPU16_ZFLAG_EN
  logic r_zflag;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_zflag <= 1'b0;
    end else if (w_commit) begin
      r_zflag <= (w_r == '0);
    end
  end

  assign o_zflag = r_zflag;
`endif

  assign o_r      = w_r;
  assign o_cout   = w_cout;
  assign o_is_alu = w_is_alu;
  assign o_s_sub  = w_sel.s_sub;
  assign o_s_fas  = w_sel.s_fas;
  assign o_s_and  = w_sel.s_and;
  assign o_s_or   = w_sel.s_or;
  assign o_s_xor  = w_sel.s_xor;
  assign o_s_not  = w_sel.s_not;
  assign o_cflag  = r_cflag;

endmodule

// File: tb/tb_cpu16_alu_core.sv
// Directed self-checking bench for cpu16_alu_core.
module tb_cpu16_alu_core;

  logic        clk;
  logic        rst_n;
  logic [15:0] ir;
  logic        exec;
  logic        host_we;
  logic [1:0]  host_addr;
  logic [15:0] host_wdata;
  logic [15:0] r;
  logic        cout;
  logic        is_alu;
  logic        s_sub, s_fas, s_and, s_or, s_xor, s_not;
  logic        cflag;
  logic [15:0] reg_a;
  logic [15:0] reg_b;
`ifdef CPU16_ZFLAG_EN
  logic        zflag;
`endif

  int n_pass;
  int n_total;

  cpu16_alu_core #(
    .WIDTH (16),
    .NREGS (4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ir         (ir),
    .i_exec       (exec),
    .i_host_we    (host_we),
    .i_host_addr  (host_addr),
    .i_host_wdata (host_wdata),
    .o_r          (r),
    .o_cout       (cout),
    .o_is_alu     (is_alu),
    .o_s_sub      (s_sub),
    .o_s_fas      (s_fas),
    .o_s_and      (s_and),
    .o_s_or       (s_or),
    .o_s_xor      (s_xor),
    .o_s_not      (s_not),
    .o_cflag      (cflag),
`ifdef CPU16_ZFLAG_EN
    .o_zflag      (zflag),
`endif
    .o_reg_a      (reg_a),
    .o_reg_b      (reg_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic host_write(input logic [1:0] addr, input logic [15:0] data);
    @(negedge clk);
    host_we    = 1'b1;
    host_addr  = addr;
    host_wdata = data;
    @(negedge clk);
    host_we    = 1'b0;
  endtask

  task automatic pulse_exec();
    @(negedge clk);
    exec = 1'b1;
    @(negedge clk);
    exec = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    exec       = 1'b1;
    host_we    = 1'b1;
    host_addr  = 2'd0;
    host_wdata = 16'hBEEF;
    ir         = 16'h0001;
    repeat (2) @(negedge clk);
    exec    = 1'b0;
    host_we = 1'b0;
    rst_n   = 1'b1;
    #1;
    n_total++;
    if (reg_a !== 16'h0000 || reg_b !== 16'h0000)
      $display("FAIL reset_r0r1 got a=%h b=%h want 0000 0000", reg_a, reg_b);
    else n_pass++;
    n_total++;
    if (cflag !== 1'b0) $display("FAIL reset_cflag got %b want 0", cflag);
    else n_pass++;
    n_total++;
    if (r !== 16'h0000 || cout !== 1'b0)
      $display("FAIL reset_add_zero got r=%h c=%b want 0000 0", r, cout);
    else n_pass++;
  endtask

  task automatic test_and();
    host_write(2'd0, 16'hFF00);
    host_write(2'd1, 16'h0101);
    ir = 16'h00A1;
    #1;
    n_total++;
    if (r !== 16'h0100 || cout !== 1'b0)
      $display("FAIL and_result got r=%h c=%b want 0100 0", r, cout);
    else n_pass++;
    n_total++;
    if ({is_alu, s_sub, s_fas, s_and, s_or, s_xor, s_not} !== 7'b1001000)
      $display("FAIL and_decode got %b want 1001000",
               {is_alu, s_sub, s_fas, s_and, s_or, s_xor, s_not});
    else n_pass++;
  endtask

  task automatic test_sub_exec();
    host_write(2'd0, 16'h0010);
    host_write(2'd1, 16'h0009);
    ir = 16'h0021;
    #1;
    n_total++;
    if (r !== 16'h0007 || cout !== 1'b1)
      $display("FAIL sub_result got r=%h c=%b want 0007 1", r, cout);
    else n_pass++;
    n_total++;
    if ({is_alu, s_sub, s_fas, s_and, s_or, s_xor, s_not} !== 7'b1110000)
      $display("FAIL sub_decode got %b want 1110000",
               {is_alu, s_sub, s_fas, s_and, s_or, s_xor, s_not});
    else n_pass++;
    pulse_exec();
    n_total++;
    if (reg_a !== 16'h0007 || cflag !== 1'b1)
      $display("FAIL sub_writeback got a=%h cf=%b want 0007 1", reg_a, cflag);
    else n_pass++;
    // 7 - 9 borrows: result wraps and carry drops
    n_total++;
    if (r !== 16'hFFFE || cout !== 1'b0 || reg_b !== 16'h0009)
      $display("FAIL sub_borrow got r=%h c=%b b=%h want fffe 0 0009", r, cout, reg_b);
    else n_pass++;
  endtask

  task automatic test_or();
    host_write(2'd0, 16'hFF00);
    host_write(2'd1, 16'h0101);
    ir = 16'h00C1;
    #1;
    n_total++;
    if (r !== 16'hFF01 || cout !== 1'b0 || s_or !== 1'b1)
      $display("FAIL or_result got r=%h c=%b s_or=%b want ff01 0 1", r, cout, s_or);
    else n_pass++;
    pulse_exec();
    n_total++;
    if (reg_a !== 16'hFF01 || cflag !== 1'b0)
      $display("FAIL or_writeback got a=%h cf=%b want ff01 0", reg_a, cflag);
    else n_pass++;
  endtask

  task automatic test_xor_add_not();
    host_write(2'd0, 16'hAA00);
    host_write(2'd1, 16'h5500);
    ir = 16'h00E1;
    #1;
    n_total++;
    if (r !== 16'hFF00 || cout !== 1'b0 || s_xor !== 1'b1)
      $display("FAIL xor_result got r=%h c=%b s_xor=%b want ff00 0 1", r, cout, s_xor);
    else n_pass++;
    ir = 16'h0001;
    #1;
    n_total++;
    if (r !== 16'hFF00 || cout !== 1'b0 || s_fas !== 1'b1 || s_sub !== 1'b0)
      $display("FAIL add_result got r=%h c=%b want ff00 0", r, cout);
    else n_pass++;
    ir = 16'h0081;
    #1;
    n_total++;
    if (r !== 16'h55FF || cout !== 1'b0 || s_not !== 1'b1)
      $display("FAIL not_result got r=%h c=%b s_not=%b want 55ff 0 1", r, cout, s_not);
    else n_pass++;
  endtask

  task automatic test_add_wrap_host();
    host_write(2'd0, 16'hFFFF);
    host_write(2'd1, 16'h0001);
    ir = 16'h0001;
    #1;
    n_total++;
    if (r !== 16'h0000 || cout !== 1'b1)
      $display("FAIL add_wrap got r=%h c=%b want 0000 1", r, cout);
    else n_pass++;
    @(negedge clk);
    exec       = 1'b1;
    host_we    = 1'b1;
    host_addr  = 2'd0;
    host_wdata = 16'h1234;
    @(negedge clk);
    exec    = 1'b0;
    host_we = 1'b0;
    #1;
    n_total++;
    if (reg_a !== 16'h1234 || cflag !== 1'b1)
      $display("FAIL host_wins got a=%h cf=%b want 1234 1", reg_a, cflag);
    else n_pass++;
  endtask

  task automatic test_illegal();
    ir = 16'h0131;
    #1;
    n_total++;
    if ({is_alu, s_sub, s_fas, s_and, s_or, s_xor, s_not} !== 7'b0 || r !== 16'h0000 ||
        cout !== 1'b0)
      $display("FAIL bad_class got sel=%b r=%h c=%b want 0 0000 0",
               {is_alu, s_sub, s_fas, s_and, s_or, s_xor, s_not}, r, cout);
    else n_pass++;
    pulse_exec();
    n_total++;
    if (reg_a !== 16'h1234 || cflag !== 1'b1)
      $display("FAIL bad_class_exec got a=%h cf=%b want 1234 1", reg_a, cflag);
    else n_pass++;
    ir = 16'h0041;
    #1;
    n_total++;
    if ({is_alu, s_sub, s_fas, s_and, s_or, s_xor, s_not} !== 7'b0 || r !== 16'h0000)
      $display("FAIL bad_func got sel=%b r=%h want 0 0000",
               {is_alu, s_sub, s_fas, s_and, s_or, s_xor, s_not}, r);
    else n_pass++;
  endtask

  task automatic test_reset_again();
    host_write(2'd2, 16'hCAFE);
    host_write(2'd3, 16'h0F0F);
    ir = 16'h000B;
    #1;
    n_total++;
    if (reg_a !== 16'hCAFE || reg_b !== 16'h0F0F)
      $display("FAIL r2r3_load got a=%h b=%h want cafe 0f0f", reg_a, reg_b);
    else n_pass++;
    @(negedge clk);
    rst_n      = 1'b0;
    exec       = 1'b1;
    host_we    = 1'b1;
    host_addr  = 2'd3;
    host_wdata = 16'h7777;
    @(negedge clk);
    rst_n   = 1'b1;
    exec    = 1'b0;
    host_we = 1'b0;
    #1;
    n_total++;
    if (reg_a !== 16'h0000 || reg_b !== 16'h0000 || r !== 16'h0000)
      $display("FAIL reset2_r2r3 got a=%h b=%h r=%h want 0000 0000 0000", reg_a, reg_b, r);
    else n_pass++;
    ir = 16'h0001;
    #1;
    n_total++;
    if (reg_a !== 16'h0000 || reg_b !== 16'h0000 || cflag !== 1'b0)
      $display("FAIL reset2_r0r1 got a=%h b=%h cf=%b want 0000 0000 0", reg_a, reg_b, cflag);
    else n_pass++;
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    rst_n      = 1'b0;
    ir         = 16'h0000;
    exec       = 1'b0;
    host_we    = 1'b0;
    host_addr  = 2'd0;
    host_wdata = 16'h0000;
    test_reset();
    test_and();
    test_sub_exec();
    test_or();
    test_xor_add_not();
    test_add_wrap_host();
    test_illegal();
    test_reset_again();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu16_alu_core.md
Name: cpu16_alu_core

Overview:
- 16-bit single-cycle datapath: register file, instruction decoder and ALU behind one 16-bit instruction register input.
- Decodes the instruction into one-hot ALU operation selects and reads two source registers.
- Presents the ALU result and carry combinationally; on an execute strobe, writes the result and carry back on the next clock edge.
- A host write port loads registers for bring-up and test.

Parameters:
- WIDTH, 16, datapath and register width.
- NREGS, 4, register count; register address width is 2.

Ports:
- clk in 1 system clock; all state updates on rising edge.
- rst_n in 1 synchronous active-low reset.
- ir in 16 instruction word.
- exec in 1 execute strobe; commits ALU writeback this cycle.
- host_we in 1 host register write enable.
- host_addr in 2 host write register index.
- host_wdata in 16 host write data.
- r out 16 combinational ALU result.
- cout out 1 combinational carry-out.
- is_alu out 1 decoded: instruction is ALU class.
- s_sub, s_fas, s_and, s_or, s_xor, s_not out 1 each; decoded one-hot operation selects.
- cflag out 1 registered carry flag.
- reg_a, reg_b out 16 each; current source operand values.

Behaviour:
- Instruction fields:
  - ir[15:8] = class; 0x00 means ALU class.
  - ir[7:4] = func.
  - ir[3:2] = ra, which is both source A and destination.
  - ir[1:0] = rb, source B.
- Decode is purely combinational:
  - is_alu = (ir[15:8]==0) and func is a legal code.
  - func 0x0 = ADD: s_fas=1.
  - func 0x2 = SUB: s_fas=1, s_sub=1.
  - func 0x8 = NOT: s_not=1.
  - func 0xA = AND: s_and=1.
  - func 0xC = OR: s_or=1.
  - func 0xE = XOR: s_xor=1.
  - Any other func, or a non-zero class, drives all selects to 0 and is_alu to 0.
- Operands: reg_a = regs[ra], reg_b = regs[rb]; asynchronous read of current register contents.
- Adder: {cout,sum} = A + (s_sub ? ~B : B) + s_sub, computed at WIDTH+1 bits.
  - SUB cout=1 means no borrow.
- Result:
  - s_fas selects sum.
  - s_and: A&B. s_or: A|B. s_xor: A^B. s_not: ~A (B ignored).
  - No select active: r=0.
  - cout=0 whenever s_fas=0.
- Writeback, at the rising edge when exec=1 and is_alu=1: regs[ra] <= r and cflag <= cout.
  - exec with is_alu=0 is a no-op.
- Host write: host_we=1 writes host_wdata to regs[host_addr] at the rising edge.
  - If exec writeback and host write target the same register in the same cycle, the host write wins.
  - cflag is still updated in that case.
- Reset (rst_n=0 at an edge): all registers and cflag become 0; host_we and exec are ignored that cycle.
  - The combinational outputs then reflect the zeroed registers.
- Latency: r and cout are valid in the same cycle as ir and the register contents; writeback becomes visible on reg_a/reg_b the cycle after the edge.
- Wrap-around: ADD/SUB results are modulo 2^16, with overflow reported only via cout.

Optional Feature:
- Macro CPU16_ZFLAG_EN.
- Defined: adds output zflag (1 bit), registered. It loads (r==0) on every committed ALU writeback, resets to 0, and is unchanged otherwise.
- Undefined: no zflag port and no zero-detect logic.

Decomposition:
- Package cpu16_pkg: WIDTH default, register address width, ALU class constant 0x00, func code constants (ADD, SUB, NOT, AND, OR, XOR), and field bit positions.
- One natural sub-module, cpu16_alu: purely combinational; inputs A, B and the six selects; outputs r and cout.
- Decoder and register file stay inline in the top module.

Test Plan:
- regs0=0xFF00, regs1=0x0101, ir=0x00A1 (AND) -> r=0x0100, cout=0, s_and=1, is_alu=1.
- regs0=0x0010, regs1=0x0009, ir=0x0021 (SUB) -> r=0x0007, cout=1. Pulse exec -> next cycle reg_a=0x0007, cflag=1.
- regs0=0xFF00, regs1=0x0101, ir=0x00C1 (OR) -> r=0xFF01, cout=0.
- regs0=0xAA00, regs1=0x5500, ir=0x00E1 (XOR) -> r=0xFF00. ir=0x0001 (ADD) -> r=0xFF00, cout=0.
- regs0=0xFFFF, regs1=0x0001, ir=0x0001 (ADD) -> r=0x0000, cout=1. Same cycle exec=1, host_we=1, host_addr=0, host_wdata=0x1234 -> regs0=0x1234, cflag=1.
- ir=0x0131 -> is_alu=0, all selects 0, r=0; exec=1 changes no state. rst_n=0 for one edge -> all regs and cflag read 0.
